// File: rtl/pipe_stage_rv.sv
// Valid/ready pipeline stage register with optional 2-entry skid buffer,
// synchronous flush and bubble masking of the control word.
module pipe_stage_rv #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CTRL_WIDTH = 16,
  parameter int unsigned SKID       = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [CTRL_WIDTH-1:0] ctrl_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CTRL_WIDTH-1:0] ctrl_o,
  output logic [1:0]            count_o
);

  logic                  main_valid_q, main_valid_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [1:0]            count_q, count_d;
  logic                  in_fire;
  logic                  out_fire;

  // Skid mode: ready depends only on state (plus the flush kill); no skid: chained ready.
  always_comb begin
    in_ready_o = 1'b0;
    if (SKID != 0) begin
      in_ready_o = !skid_valid_q && !flush_i;
    end else begin
      in_ready_o = (!main_valid_q || out_ready_i) && !flush_i;
    end
  end

  assign in_fire  = in_valid_i && in_ready_o;
  assign out_fire = main_valid_q && out_ready_i;

  // Next-state: main is the head; skid only fills when main is held.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_ctrl_d  = main_ctrl_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (out_fire) begin
        main_data_d  = skid_data_q;
        main_ctrl_d  = skid_ctrl_q;
        skid_valid_d = 1'b0;
      end
    end else if (!main_valid_q || out_fire) begin
      main_valid_d = in_fire;
      if (in_fire) begin
        main_data_d = data_i;
        main_ctrl_d = ctrl_i;
      end
    end else if (in_fire && (SKID != 0)) begin
      skid_valid_d = 1'b1;
      skid_data_d  = data_i;
      skid_ctrl_d  = ctrl_i;
    end
    count_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_ctrl_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= '0;
      count_q      <= 2'd0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
      count_q      <= count_d;
    end
  end

  assign out_valid_o = main_valid_q;
  assign data_o      = main_data_q;
  assign ctrl_o      = main_valid_q ? main_ctrl_q : '0;
  assign count_o     = count_q;

endmodule

// File: tb/tb_pipe_stage_rv.sv
// Bench for pipe_stage_rv: SKID=1 and SKID=0 instances share stimulus, each
// checked against its own reference FIFO plus hand-derived vectors.
module tb_pipe_stage_rv;

  localparam int unsigned DW = 64;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst_n, flush_i, in_valid_i, out_ready_i;
  logic [DW-1:0] data_i;
  logic [CW-1:0] ctrl_i;

  logic          rdy1, ov1, rdy0, ov0;
  logic [DW-1:0] dout1, dout0;
  logic [CW-1:0] cout1, cout0;
  logic [1:0]    cnt1, cnt0;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
  } entry_t;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic          ordy;
    logic          fl;
    logic [1:0]    cnt;
    logic          rdy;
  } vec_t;

  entry_t q1[$];
  entry_t q0[$];
  vec_t   vecs[$];

  always #5 clk = ~clk;

  pipe_stage_rv #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .SKID(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(rdy1), .data_i(data_i), .ctrl_i(ctrl_i),
    .out_valid_o(ov1), .out_ready_i(out_ready_i), .data_o(dout1), .ctrl_o(cout1),
    .count_o(cnt1)
  );

  pipe_stage_rv #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .SKID(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(rdy0), .data_i(data_i), .ctrl_i(ctrl_i),
    .out_valid_o(ov0), .out_ready_i(out_ready_i), .data_o(dout0), .ctrl_o(cout0),
    .count_o(cnt0)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference FIFO model: capacity 2 with state-only ready, or capacity 1 with chained ready.
  task automatic score(input bit m, input logic rdy, input logic ov, input logic [DW-1:0] dout,
                       input logic [CW-1:0] cout, input logic [1:0] cnt);
    int     sz;
    logic   exp_rdy;
    entry_t e;
    string  p;
    p  = m ? "skid1" : "skid0";
    sz = m ? q1.size() : q0.size();
    exp_rdy = !flush_i && (m ? (sz < 2) : (sz == 0 || out_ready_i));
    chk({p, ".count"}, 64'(cnt), 64'(sz));
    chk({p, ".out_valid"}, 64'(ov), 64'(sz > 0));
    chk({p, ".in_ready"}, 64'(rdy), 64'(exp_rdy));
    if (sz == 0) chk({p, ".ctrl_bubble"}, 64'(cout), 64'd0);
    if (sz > 0 && out_ready_i) begin
      if (m) e = q1.pop_front();
      else   e = q0.pop_front();
      chk({p, ".data_out"}, dout, e.data);
      chk({p, ".ctrl_out"}, 64'(cout), 64'(e.ctrl));
    end
    if (flush_i) begin
      if (m) q1.delete();
      else   q0.delete();
    end
    if (in_valid_i && exp_rdy) begin
      if (m) q1.push_back('{data: data_i, ctrl: ctrl_i});
      else   q0.push_back('{data: data_i, ctrl: ctrl_i});
    end
  endtask

  // One cycle: drive at the falling edge, sample 1 time unit later.
  task automatic step(input logic rn, input logic fl, input logic iv, input logic [DW-1:0] d,
                      input logic [CW-1:0] c, input logic ordy);
    @(negedge clk);
    rst_n = rn; flush_i = fl; in_valid_i = iv; data_i = d; ctrl_i = c; out_ready_i = ordy;
    #1;
    if (rn) begin
      score(1'b1, rdy1, ov1, dout1, cout1, cnt1);
      score(1'b0, rdy0, ov0, dout0, cout0, cnt0);
    end else begin
      q1.delete();
      q0.delete();
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                              input logic ordy, input logic fl, input logic [1:0] cnt,
                              input logic rdy);
    vec_t v;
    v.iv = iv; v.d = d; v.c = c; v.ordy = ordy; v.fl = fl; v.cnt = cnt; v.rdy = rdy;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b1;
    data_i = 64'hDEAD; ctrl_i = '0; out_ready_i = 1'b0;

    // Expected count/in_ready of the SKID=1 instance in each row's cycle.
    for (int n = 1; n <= 8; n++)
      vecs.push_back(mk(1'b1, 64'(n), 16'(16'h10 + n), 1'b1, 1'b0, (n == 1) ? 2'd0 : 2'd1, 1'b1));
    vecs.push_back(mk(1'b0, 64'h0,  16'h0,  1'b1, 1'b0, 2'd1, 1'b1));
    vecs.push_back(mk(1'b0, 64'h0,  16'h0,  1'b1, 1'b0, 2'd0, 1'b1));
    vecs.push_back(mk(1'b1, 64'h11, 16'h01, 1'b0, 1'b0, 2'd0, 1'b1));
    vecs.push_back(mk(1'b1, 64'h22, 16'h02, 1'b0, 1'b0, 2'd1, 1'b1));
    vecs.push_back(mk(1'b1, 64'h33, 16'h03, 1'b0, 1'b0, 2'd2, 1'b0));
    vecs.push_back(mk(1'b1, 64'h33, 16'h03, 1'b0, 1'b0, 2'd2, 1'b0));
    vecs.push_back(mk(1'b1, 64'h33, 16'h03, 1'b1, 1'b0, 2'd2, 1'b0));
    vecs.push_back(mk(1'b1, 64'h33, 16'h03, 1'b1, 1'b0, 2'd1, 1'b1));
    vecs.push_back(mk(1'b0, 64'h0,  16'h0,  1'b1, 1'b0, 2'd1, 1'b1));
    vecs.push_back(mk(1'b0, 64'h0,  16'h0,  1'b0, 1'b0, 2'd0, 1'b1));
    vecs.push_back(mk(1'b1, 64'h55, 16'h05, 1'b0, 1'b0, 2'd0, 1'b1));
    vecs.push_back(mk(1'b1, 64'h66, 16'h06, 1'b0, 1'b0, 2'd1, 1'b1));
    vecs.push_back(mk(1'b1, 64'h44, 16'h04, 1'b0, 1'b1, 2'd2, 1'b0));
    vecs.push_back(mk(1'b1, 64'h44, 16'h04, 1'b0, 1'b0, 2'd0, 1'b1));
    vecs.push_back(mk(1'b0, 64'h0,  16'h0,  1'b1, 1'b0, 2'd1, 1'b1));
    vecs.push_back(mk(1'b0, 64'h0,  16'h0,  1'b0, 1'b0, 2'd0, 1'b1));
    vecs.push_back(mk(1'b1, 64'h77, 16'h07, 1'b0, 1'b0, 2'd0, 1'b1));
    vecs.push_back(mk(1'b0, 64'h0,  16'h0,  1'b1, 1'b1, 2'd1, 1'b0));
    vecs.push_back(mk(1'b0, 64'h0,  16'h0,  1'b0, 1'b0, 2'd0, 1'b1));

    // Reset held for two edges with a valid upstream entry present.
    step(1'b0, 1'b0, 1'b1, 64'hDEAD, 16'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 64'hDEAD, 16'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 64'h0, 16'h0, 1'b0);
    chk("reset.data1", dout1, 64'h0);
    chk("reset.data0", dout0, 64'h0);
    chk("reset.ctrl1", 64'(cout1), 64'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(1'b1, vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].c, vecs[i].ordy);
      chk($sformatf("vec%0d.count", i), 64'(cnt1), 64'(vecs[i].cnt));
      chk($sformatf("vec%0d.in_ready", i), 64'(rdy1), 64'(vecs[i].rdy));
    end

    // Single-entry mode: held head blocks input until downstream is ready.
    step(1'b1, 1'b0, 1'b1, 64'h99, 16'h09, 1'b0);
    step(1'b1, 1'b0, 1'b1, 64'hAA, 16'h0A, 1'b0);
    chk("s0.stall_count", 64'(cnt0), 64'd1);
    chk("s0.stall_ready", 64'(rdy0), 64'd0);
    step(1'b1, 1'b0, 1'b1, 64'hBB, 16'h0B, 1'b1);
    chk("s0.pass_ready", 64'(rdy0), 64'd1);
    step(1'b1, 1'b0, 1'b1, 64'hCC, 16'h0C, 1'b0);
    chk("s0.replace_count", 64'(cnt0), 64'd1);
    chk("s0.replace_data", dout0, 64'hBB);
    chk("s0.replace_ctrl", 64'(cout0), 64'h0B);

    // Reset mid-operation with the skid full, overriding flush and handshake.
    step(1'b1, 1'b0, 1'b0, 64'h0, 16'h0, 1'b0);
    chk("s1.full_count", 64'(cnt1), 64'd2);
    step(1'b0, 1'b1, 1'b1, 64'hEE, 16'h0E, 1'b1);
    step(1'b1, 1'b0, 1'b0, 64'h0, 16'h0, 1'b0);
    chk("midrst.data1", dout1, 64'h0);
    chk("midrst.data0", dout0, 64'h0);
    chk("midrst.count1", 64'(cnt1), 64'd0);
    chk("midrst.ready1", 64'(rdy1), 64'd1);
    step(1'b1, 1'b0, 1'b0, 64'h0, 16'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
